// File: rtl/weight_update_feeder.sv
// rtl/weight_update_feeder.sv - weight-RAM burst responder: preload on start, refill on update_weight_ram
module weight_update_feeder #(
    parameter int DATA_WIDTH              = 16,
    parameter int KERNEL_SIZE_MAX         = 3,
    parameter int PARA_KERNEL             = 2,
    parameter int WEIGHT_WRITE_ADDR_WIDTH = 8,
    parameter int SRC_ADDR_WIDTH          = 12,
    parameter int BEATS_WIDTH             = 4
) (
    input  logic                                                          clk,
    input  logic                                                          rst,
    input  logic                                                          start,
    input  logic [BEATS_WIDTH-1:0]                                        cfg_beats,
    input  logic [SRC_ADDR_WIDTH-1:0]                                     cfg_src_base,
    input  logic [SRC_ADDR_WIDTH-1:0]                                     cfg_src_end,
    input  logic                                                          update_weight_ram,
    input  logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0]                update_weight_ram_addr,
    output logic                                                          src_rd_en,
    output logic [SRC_ADDR_WIDTH-1:0]                                     src_rd_addr,
    input  logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] src_rd_data,
    output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] weight_data,
    output logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0]                write_weight_data_addr,
    output logic                                                          weight_data_done,
    output logic                                                          busy,
    output logic                                                          err_req_busy
);

    localparam int LANE_W = WEIGHT_WRITE_ADDR_WIDTH;
    localparam logic [BEATS_WIDTH-1:0] ONE_BEAT = BEATS_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE,
        WAIT_LOW
    } state_t;

    state_t                                   state;
    state_t                                   state_next;
    logic [BEATS_WIDTH-1:0]                   n_beats;
    logic [BEATS_WIDTH-1:0]                   issue_cnt;
    logic [BEATS_WIDTH-1:0]                   cap_cnt;
    logic [BEATS_WIDTH-1:0]                   beats_eff;
    logic [SRC_ADDR_WIDTH-1:0]                src_ptr;
    logic [SRC_ADDR_WIDTH:0]                  ptr_sum;
    logic [LANE_W*PARA_KERNEL-1:0]            lane_base;
    logic [LANE_W*PARA_KERNEL-1:0]            lane_addr_next;
    logic                                     from_req;
    logic                                     armed;
    logic                                     req_d;
    logic                                     cap_valid;
    logic                                     go_start;
    logic                                     go_req;

    always_comb begin
        go_start   = 1'b0;
        go_req     = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                go_start = start;
                go_req   = !start && update_weight_ram && armed;
                if (go_start || go_req) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (issue_cnt == n_beats - ONE_BEAT) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:    state_next = DONE;
            DONE:     state_next = from_req ? WAIT_LOW : IDLE;
            WAIT_LOW: begin
                if (!update_weight_ram) begin
                    state_next = IDLE;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    // Each lane wraps within its own address field; no carry crosses lanes.
    always_comb begin
        lane_addr_next = '0;
        for (int j = 0; j < PARA_KERNEL; j++) begin
            lane_addr_next[j*LANE_W +: LANE_W] = lane_base[j*LANE_W +: LANE_W] + LANE_W'(cap_cnt);
        end
    end

    always_comb begin
        beats_eff = (cfg_beats == '0) ? ONE_BEAT : cfg_beats;
        ptr_sum   = {1'b0, src_ptr} + (SRC_ADDR_WIDTH + 1)'(n_beats);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            n_beats                <= '0;
            issue_cnt              <= '0;
            cap_cnt                <= '0;
            src_ptr                <= '0;
            lane_base              <= '0;
            from_req               <= 1'b0;
            armed                  <= 1'b1;
            req_d                  <= 1'b0;
            cap_valid              <= 1'b0;
            src_rd_en              <= 1'b0;
            src_rd_addr            <= '0;
            weight_data            <= '0;
            write_weight_data_addr <= '0;
            weight_data_done       <= 1'b0;
            busy                   <= 1'b0;
            err_req_busy           <= 1'b0;
        end else begin
            state     <= state_next;
            req_d     <= update_weight_ram;
            cap_valid <= src_rd_en;

            // A request must be seen low before it may launch another burst.
            if (!update_weight_ram) begin
                armed <= 1'b1;
            end
            if (update_weight_ram && !req_d && busy) begin
                err_req_busy <= 1'b1;
                armed        <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (go_start || go_req) begin
                        busy             <= 1'b1;
                        weight_data_done <= 1'b0;
                        n_beats          <= beats_eff;
                        issue_cnt        <= '0;
                        cap_cnt          <= '0;
                        src_rd_en        <= 1'b1;
                        from_req         <= go_req;
                        if (go_start) begin
                            src_ptr     <= cfg_src_base;
                            src_rd_addr <= cfg_src_base;
                            lane_base   <= '0;
                            if (update_weight_ram) begin
                                armed <= 1'b0;
                            end
                        end else begin
                            src_rd_addr <= src_ptr;
                            lane_base   <= update_weight_ram_addr;
                            armed       <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    if (state_next == DRAIN) begin
                        src_rd_en <= 1'b0;
                    end else begin
                        src_rd_addr <= src_rd_addr + SRC_ADDR_WIDTH'(1);
                        issue_cnt   <= issue_cnt + ONE_BEAT;
                    end
                end
                DONE: begin
                    weight_data_done <= 1'b1;
                    busy             <= 1'b0;
                    // The next burst restarts at the region base once it would run past the end.
                    if (ptr_sum > {1'b0, cfg_src_end}) begin
                        src_ptr <= cfg_src_base;
                    end else begin
                        src_ptr <= ptr_sum[SRC_ADDR_WIDTH-1:0];
                    end
                end
                default: ;
            endcase

            if (cap_valid) begin
                weight_data            <= src_rd_data;
                write_weight_data_addr <= lane_addr_next;
                cap_cnt                <= cap_cnt + ONE_BEAT;
            end
        end
    end

endmodule

// File: doc/weight_update_feeder.md
Name: weight_update_feeder

Overview:
- Host-side responder for the accelerator's weight-RAM write interface: on an `update_weight_ram` request it fetches `cfg_beats` weight beats from a synchronous source buffer and drives `weight_data` / `write_weight_data_addr` / `weight_data_done` back into the layer core.
- Also performs the initial weight preload on a `start` pulse.
- Sits between the weight DMA buffer and the layer core; replaces the bench-driven weight handshake.

Parameters:
- DATA_WIDTH, 16, bits per float16 weight
- KERNEL_SIZE_MAX, 3, kernel edge; each beat carries KERNEL_SIZE_MAX^2 weights per kernel lane
- PARA_KERNEL, 2, kernels written in parallel (address lanes)
- WEIGHT_WRITE_ADDR_WIDTH, 8, per-lane weight RAM address width
- SRC_ADDR_WIDTH, 12, source buffer address width
- BEATS_WIDTH, 4, width of beat counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin initial preload
- cfg_beats  in  BEATS_WIDTH  beats per burst (0 treated as 1)
- cfg_src_base  in  SRC_ADDR_WIDTH  first source word of weight region
- cfg_src_end  in  SRC_ADDR_WIDTH  last valid source word (inclusive)
- update_weight_ram  in  1  level request from layer core
- update_weight_ram_addr  in  WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL  per-lane base write address
- src_rd_en  out  1  source read strobe
- src_rd_addr  out  SRC_ADDR_WIDTH  source read address
- src_rd_data  in  KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH  read data, valid the cycle after src_rd_en
- weight_data  out  same width as src_rd_data  beat to weight RAM
- write_weight_data_addr  out  WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL  per-lane write address
- weight_data_done  out  1  0 while writing, 1 when burst complete
- busy  out  1  burst in progress
- err_req_busy  out  1  sticky: request arrived while busy

Behaviour:
- **Reset values:**
  - All outputs are 0, including weight_data_done. The internal src_ptr resets to 0.
  - The state machine resets to IDLE, disarmed-safe (armed=1).
  - Reset mid-burst aborts immediately with no further writes.
- **States:** IDLE, FETCH, DRAIN, DONE, WAIT_LOW.
- **IDLE:**
  - `start`=1:
    - src_ptr <= cfg_src_base.
    - Per-lane bases are set to 0.
    - Go to FETCH.
  - Otherwise, `update_weight_ram`=1 and armed:
    - Latch update_weight_ram_addr as per-lane bases.
    - Go to FETCH.
  - `start` has priority over a simultaneous request; that request is then ignored.
  - On leaving IDLE:
    - weight_data_done <= 0 and busy <= 1.
    - The beat count n is set to max(cfg_beats,1). cfg_beats is sampled at this edge and held for the whole burst.
- **FETCH:**
  - src_rd_en=1 for n consecutive cycles.
  - src_rd_addr = src_ptr + i for i = 0..n-1, all outputs registered.
  - After the nth issue go to DRAIN.
- **Data path:**
  - Each source read returns one cycle later.
  - On the following edge: weight_data <= src_rd_data, and each lane j field of write_weight_data_addr <= base_j + k, mod 2^WEIGHT_WRITE_ADDR_WIDTH (per-lane wrap, no carry between lanes).
  - Beat k is visible for exactly one cycle with weight_data_done=0.
- **Latency:** with the request sampled at edge E0:
  - src_rd_en is high after E0..E0+n-1.
  - Beat k is presented after edge E0+2+k.
  - weight_data_done <= 1 at edge E0+n+2.
  - busy <= 0 at edge E0+n+2.
- **DONE:**
  - weight_data and write_weight_data_addr hold the last beat.
  - src_ptr advances by n. If src_ptr+n > cfg_src_end, src_ptr wraps to cfg_src_base.
  - A burst that itself straddles cfg_src_end is not split; the address simply continues.
  - Next state: WAIT_LOW if the burst came from a request, else IDLE.
- **WAIT_LOW:** wait until update_weight_ram=0, then go to IDLE. This prevents a held level request from re-triggering.
- **Error flag:** update_weight_ram rising while busy=1 sets err_req_busy (sticky until rst); the request is dropped.
- **Done polarity:** weight_data_done stays 1 in IDLE/WAIT_LOW after the first completed burst.

Test Plan:
1. **Preload:** cfg_src_base=0, cfg_beats=2, src_rd_data=mem[addr], `start` pulse.
   - src_rd_addr 0,1 on consecutive cycles.
   - write_weight_data_addr lanes {0,0} then {1,1} with mem[0], mem[1].
   - weight_data_done=1 four cycles after start is sampled.
2. **Update request:** after preload, assert update_weight_ram with lane addrs {16,16} (held high).
   - Reads at 2,3; writes to {16,16},{17,17}.
   - done=1 at E0+4.
   - No second burst while the request stays high; re-arms after the request drops.
3. **Source wrap:** cfg_src_base=0, cfg_src_end=5, cfg_beats=2, four back-to-back requests.
   - Reads 0-1, 2-3, 4-5, then 0-1.
4. **Lane-address wrap and edge cases:**
   - Lane base 255, cfg_beats=2 → beat 1 addr 0 in that lane; other lanes unaffected.
   - cfg_beats=0 → exactly one beat.
5. **Collision / simultaneity:**
   - Request pulse while busy → err_req_busy=1; burst count unchanged.
   - `start` and request in the same cycle → preload from cfg_src_base; the request is ignored.
6. **Reset mid-burst:** rst at E0+2.
   - Next cycle: src_rd_en=0, done=0, busy=0, state IDLE.
   - A fresh request then starts from src_ptr=0.
